// File: rtl/mode_controller_if.sv
// Button inputs and display/generator outputs of the tuner/metronome menu.
// master drives the buttons; slave is the controller.
interface mode_controller_if;
   logic       btn_next;
   logic       btn_mode;
   logic       btn_select;
   logic [7:0] stateNum;
   logic       tone_en;
   logic       metro_en;
   logic [2:0] note_sel;
   logic [1:0] bpm_sel;

   modport master (
      output btn_next, btn_mode, btn_select,
      input  stateNum, tone_en, metro_en, note_sel, bpm_sel
   );

   modport slave (
      input  btn_next, btn_mode, btn_select,
      output stateNum, tone_en, metro_en, note_sel, bpm_sel
   );
endinterface

// File: rtl/mode_controller.sv
// Tuner/metronome menu FSM: synchronised, debounced buttons in,
// stateNum code plus tone/metronome enables and selects out.
module mode_controller #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input logic               clk,
   input logic               reset,
   mode_controller_if.slave  bus
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   localparam logic [7:0] S_IDLE     = 8'd0;
   localparam logic [7:0] S_E2       = 8'd1;
   localparam logic [7:0] S_W12      = 8'd12;
   localparam logic [7:0] S_M60      = 8'd13;
   localparam logic [7:0] S_W20      = 8'd20;
   localparam logic [7:0] S_TO_METRO = 8'd22;
   localparam logic [7:0] S_TO_TUNER = 8'd24;

   function automatic logic f_tdisp(input logic [7:0] s);
      return s[0] && (s <= 8'd11);
   endfunction

   function automatic logic f_mdisp(input logic [7:0] s);
      return s[0] && (s >= 8'd13) && (s <= 8'd19);
   endfunction

   function automatic logic f_wait(input logic [7:0] s);
      return !s[0] && (s >= 8'd2) && (s <= 8'd20);
   endfunction

   // bit 0 = next, bit 1 = mode, bit 2 = select
   logic [2:0]    w_raw;
   logic [2:0]    r_sync1;
   logic [2:0]    r_sync2;
   logic [2:0]    r_deb;
   logic [CW-1:0] r_cnt [3];

   assign w_raw = {bus.btn_select, bus.btn_mode, bus.btn_next};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_deb   <= '0;
         for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
         for (int i = 0; i < 3; i++) begin
            if (r_sync2[i] == r_deb[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == CNT_MAX) begin
               r_deb[i] <= r_sync2[i];
               r_cnt[i] <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + CW'(1);
            end
         end
      end
   end

   logic       w_n;
   logic       w_m;
   logic       w_sel_rise;
   logic       r_sel_q;
   logic [7:0] r_state;
   logic [7:0] w_nxt;
   logic       r_run;
   logic       w_run_nxt;
   logic       r_tone;
   logic       r_metro;
   logic [2:0] r_note;
   logic [1:0] r_bpm;
   logic       w_idle;
   logic       w_tdisp;
   logic       w_mdisp;
   logic       w_wait;
   logic       w_tomet;
   logic       w_totun;

   assign w_n        = r_deb[0];
   assign w_m        = r_deb[1];
   assign w_sel_rise = r_deb[2] && !r_sel_q;

   assign w_idle  = (r_state == S_IDLE);
   assign w_tdisp = f_tdisp(r_state);
   assign w_mdisp = f_mdisp(r_state);
   assign w_wait  = f_wait(r_state);
   assign w_tomet = (r_state == S_TO_METRO);
   assign w_totun = (r_state == S_TO_TUNER);

   always_comb begin
      w_nxt = r_state;
      unique case (1'b1)
         w_idle:  if (w_m) w_nxt = S_TO_TUNER;
         w_tdisp: begin
            if (w_m)      w_nxt = S_TO_METRO;
            else if (w_n) w_nxt = r_state + 8'd1;
         end
         w_mdisp: begin
            if (w_m)      w_nxt = S_TO_TUNER;
            else if (w_n) w_nxt = r_state + 8'd1;
         end
         w_wait: begin
            if (!w_n) begin
               if (r_state == S_W12)      w_nxt = S_E2;
               else if (r_state == S_W20) w_nxt = S_M60;
               else                       w_nxt = r_state + 8'd1;
            end
         end
         w_tomet: if (!w_m) w_nxt = S_M60;
         w_totun: if (!w_m) w_nxt = S_E2;
         default: w_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_run_nxt = r_run;
      if (w_nxt == S_TO_METRO || w_nxt == S_TO_TUNER)
         w_run_nxt = 1'b0;
      else if ((w_tdisp || w_mdisp) && w_sel_rise)
         w_run_nxt = ~r_run;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_sel_q <= 1'b0;
         r_run   <= 1'b0;
         r_tone  <= 1'b0;
         r_metro <= 1'b0;
         r_note  <= '0;
         r_bpm   <= '0;
      end else begin
         r_state <= w_nxt;
         r_sel_q <= r_deb[2];
         r_run   <= w_run_nxt;
         r_tone  <= w_run_nxt && f_tdisp(w_nxt);
         r_metro <= w_run_nxt && f_mdisp(w_nxt);
         // display codes map directly onto the select values
         if (f_tdisp(w_nxt)) r_note <= w_nxt[3:1];
         if (f_mdisp(w_nxt)) r_bpm  <= {~w_nxt[2], w_nxt[1]};
      end
   end

   assign bus.stateNum = r_state;
   assign bus.tone_en  = r_tone;
   assign bus.metro_en = r_metro;
   assign bus.note_sel = r_note;
   assign bus.bpm_sel  = r_bpm;

endmodule

// File: tb/tb_mode_controller.sv
// Directed vector bench for mode_controller with a 4-cycle debounce.
// Button changes take 7 clocks to reach stateNum.
module tb_mode_controller;

   logic clk;
   logic reset;
   int   n_err;
   int   n_chk;

   mode_controller_if bus ();

   mode_controller #(
      .DEBOUNCE_CYCLES(4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       n;
      logic       m;
      logic       s;
      int         cyc;
      logic [7:0] st;
      logic       te;
      logic       me;
      logic [2:0] ns;
      logic [1:0] bs;
   } vec_t;

   vec_t tv [21];

   task automatic step(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic chk(input string nm, input logic [7:0] st,
                      input logic te, input logic me,
                      input logic [2:0] ns, input logic [1:0] bs);
      logic [14:0] act;
      logic [14:0] exp;
      act = {bus.stateNum, bus.tone_en, bus.metro_en,
             bus.note_sel, bus.bpm_sel};
      exp = {st, te, me, ns, bs};
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got st=%0d te=%0b me=%0b ns=%0d bs=%0d, want st=%0d te=%0b me=%0b ns=%0d bs=%0d",
                  nm, bus.stateNum, bus.tone_en, bus.metro_en,
                  bus.note_sel, bus.bpm_sel, st, te, me, ns, bs);
      end
   endtask

   task automatic apply(input int i);
      bus.btn_next   = tv[i].n;
      bus.btn_mode   = tv[i].m;
      bus.btn_select = tv[i].s;
      step(tv[i].cyc);
      chk($sformatf("vec%0d", i), tv[i].st, tv[i].te,
          tv[i].me, tv[i].ns, tv[i].bs);
   endtask

   initial begin
      n_err = 0;
      n_chk = 0;

      // tuner walk with wrap 12 -> 1
      tv[0]  = '{1'b1, 1'b0, 1'b0, 7, 8'd2,  1'b0, 1'b0, 3'd0, 2'd0};
      tv[1]  = '{1'b0, 1'b0, 1'b0, 7, 8'd3,  1'b0, 1'b0, 3'd1, 2'd0};
      tv[2]  = '{1'b1, 1'b0, 1'b0, 7, 8'd4,  1'b0, 1'b0, 3'd1, 2'd0};
      tv[3]  = '{1'b0, 1'b0, 1'b0, 7, 8'd5,  1'b0, 1'b0, 3'd2, 2'd0};
      tv[4]  = '{1'b1, 1'b0, 1'b0, 7, 8'd6,  1'b0, 1'b0, 3'd2, 2'd0};
      tv[5]  = '{1'b0, 1'b0, 1'b0, 7, 8'd7,  1'b0, 1'b0, 3'd3, 2'd0};
      tv[6]  = '{1'b1, 1'b0, 1'b0, 7, 8'd8,  1'b0, 1'b0, 3'd3, 2'd0};
      tv[7]  = '{1'b0, 1'b0, 1'b0, 7, 8'd9,  1'b0, 1'b0, 3'd4, 2'd0};
      tv[8]  = '{1'b1, 1'b0, 1'b0, 7, 8'd10, 1'b0, 1'b0, 3'd4, 2'd0};
      tv[9]  = '{1'b0, 1'b0, 1'b0, 7, 8'd11, 1'b0, 1'b0, 3'd5, 2'd0};
      tv[10] = '{1'b1, 1'b0, 1'b0, 7, 8'd12, 1'b0, 1'b0, 3'd5, 2'd0};
      tv[11] = '{1'b0, 1'b0, 1'b0, 7, 8'd1,  1'b0, 1'b0, 3'd0, 2'd0};
      // metronome walk from 13 with run toggled in 15
      tv[12] = '{1'b1, 1'b0, 1'b0, 7, 8'd14, 1'b0, 1'b0, 3'd2, 2'd0};
      tv[13] = '{1'b0, 1'b0, 1'b0, 7, 8'd15, 1'b0, 1'b0, 3'd2, 2'd1};
      tv[14] = '{1'b0, 1'b0, 1'b1, 7, 8'd15, 1'b0, 1'b1, 3'd2, 2'd1};
      tv[15] = '{1'b0, 1'b0, 1'b0, 7, 8'd15, 1'b0, 1'b1, 3'd2, 2'd1};
      tv[16] = '{1'b1, 1'b0, 1'b0, 7, 8'd16, 1'b0, 1'b0, 3'd2, 2'd1};
      tv[17] = '{1'b0, 1'b0, 1'b0, 7, 8'd17, 1'b0, 1'b1, 3'd2, 2'd2};
      tv[18] = '{1'b1, 1'b0, 1'b0, 7, 8'd18, 1'b0, 1'b0, 3'd2, 2'd2};
      tv[19] = '{1'b0, 1'b0, 1'b0, 7, 8'd19, 1'b0, 1'b1, 3'd2, 2'd3};
      tv[20] = '{1'b1, 1'b0, 1'b0, 7, 8'd20, 1'b0, 1'b0, 3'd2, 2'd3};

      reset          = 1'b0;
      bus.btn_next   = 1'b0;
      bus.btn_mode   = 1'b0;
      bus.btn_select = 1'b0;
      step(2);
      chk("reset", 8'd0, 1'b0, 1'b0, 3'd0, 2'd0);
      reset = 1'b1;
      step(2);

      // mode press from IDLE: exact latency both ways
      bus.btn_mode = 1'b1;
      step(6);
      chk("idle_mode_early", 8'd0, 1'b0, 1'b0, 3'd0, 2'd0);
      step(1);
      chk("idle_mode_24", 8'd24, 1'b0, 1'b0, 3'd0, 2'd0);
      step(5);
      bus.btn_mode = 1'b0;
      step(6);
      chk("hold_24", 8'd24, 1'b0, 1'b0, 3'd0, 2'd0);
      step(1);
      chk("to_e2", 8'd1, 1'b0, 1'b0, 3'd0, 2'd0);

      for (int i = 0; i < 12; i++) apply(i);

      bus.btn_next = 1'b1;
      step(7);
      chk("t3_w2", 8'd2, 1'b0, 1'b0, 3'd0, 2'd0);
      bus.btn_next = 1'b0;
      step(7);
      chk("t3_a2", 8'd3, 1'b0, 1'b0, 3'd1, 2'd0);

      // 3-clk glitch must be rejected and leave the counter cleared
      bus.btn_next = 1'b1;
      step(3);
      bus.btn_next = 1'b0;
      step(10);
      chk("glitch", 8'd3, 1'b0, 1'b0, 3'd1, 2'd0);
      bus.btn_next = 1'b1;
      step(6);
      chk("post_glitch_early", 8'd3, 1'b0, 1'b0, 3'd1, 2'd0);
      step(1);
      chk("post_glitch_w4", 8'd4, 1'b0, 1'b0, 3'd1, 2'd0);
      bus.btn_next = 1'b0;
      step(7);
      chk("d3", 8'd5, 1'b0, 1'b0, 3'd2, 2'd0);

      bus.btn_select = 1'b1;
      step(7);
      chk("run_on", 8'd5, 1'b1, 1'b0, 3'd2, 2'd0);
      bus.btn_select = 1'b0;
      step(7);
      chk("run_hold", 8'd5, 1'b1, 1'b0, 3'd2, 2'd0);

      // mode wins over next when both rise together
      bus.btn_mode = 1'b1;
      bus.btn_next = 1'b1;
      step(7);
      chk("to_metro", 8'd22, 1'b0, 1'b0, 3'd2, 2'd0);
      bus.btn_mode = 1'b0;
      bus.btn_next = 1'b0;
      step(7);
      chk("m60", 8'd13, 1'b0, 1'b0, 3'd2, 2'd0);

      for (int i = 12; i < 21; i++) apply(i);

      // asynchronous reset mid-wait with select held
      bus.btn_select = 1'b1;
      step(3);
      reset = 1'b0;
      #1;
      chk("async_reset", 8'd0, 1'b0, 1'b0, 3'd0, 2'd0);
      step(3);
      chk("reset_held", 8'd0, 1'b0, 1'b0, 3'd0, 2'd0);
      reset = 1'b1;
      bus.btn_next = 1'b0;
      step(10);
      chk("post_reset_idle", 8'd0, 1'b0, 1'b0, 3'd0, 2'd0);
      bus.btn_mode = 1'b1;
      step(6);
      chk("pr_mode_early", 8'd0, 1'b0, 1'b0, 3'd0, 2'd0);
      step(1);
      chk("pr_mode_24", 8'd24, 1'b0, 1'b0, 3'd0, 2'd0);
      bus.btn_mode = 1'b0;
      step(7);
      chk("pr_e2_no_run", 8'd1, 1'b0, 1'b0, 3'd0, 2'd0);
      bus.btn_select = 1'b0;
      step(7);
      chk("pr_sel_rel", 8'd1, 1'b0, 1'b0, 3'd0, 2'd0);
      bus.btn_select = 1'b1;
      step(7);
      chk("pr_run_on", 8'd1, 1'b1, 1'b0, 3'd0, 2'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
